encoder_param_ctrl: RTL and testbench

Front-panel controller for the signal generator. It decodes the rotary encoder and a push button, and applies encoder steps to one of three generator parameters: frequency index, amplitude, and waveform. Each changed parameter is pushed to the generator configuration bus over a valid/ready handshake. Rapid changes to a field are coalesced, so the latest value is always what gets committed.

---
 rtl/encoder_param_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_encoder_param_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_param_ctrl.sv
// Front-panel controller: quadrature encoder and push button edit three
// generator parameters, and each changed parameter is committed over cfg_*.
module encoder_param_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FREQ_MAX        = 255,
    parameter int AMP_MAX         = 100,
    parameter int WAVE_COUNT      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       btn,
    input  logic       cfg_ready,
    output logic [1:0] field_sel,
    output logic [7:0] freq_val,
    output logic [7:0] amp_val,
    output logic [1:0] wave_val,
    output logic       cfg_valid,
    output logic [1:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       enc_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [1:0]       a_sync;
    logic [1:0]       b_sync;
    logic [1:0]       btn_sync;
    logic [1:0]       enc_prev;
    logic [1:0]       enc_cur;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_stable;
    logic             db_done;
    logic             press;
    logic             step_up;
    logic             step_dn;
    logic             illegal;
    logic [2:0]       dirty;
    logic [2:0]       dirty_set;
    logic [2:0]       dirty_clr;
    logic [0:0]       state;
    logic [7:0]       freq_nxt;
    logic [7:0]       amp_nxt;
    logic [1:0]       wave_nxt;
    logic [1:0]       pick_idx;
    logic [7:0]       pick_data;

    assign enc_cur = {a_sync[1], b_sync[1]};
    assign step_up = (enc_prev == 2'b00) && (enc_cur == 2'b01);
    assign step_dn = (enc_prev == 2'b00) && (enc_cur == 2'b10);
    assign illegal = (enc_prev ^ enc_cur) == 2'b11;

    assign db_done = (btn_sync[1] != btn_stable) &&
                     (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press   = db_done && btn_sync[1];

    // Saturating/wrapping step on the selected field; blocked steps stay clean.
    always_comb begin
        freq_nxt  = freq_val;
        amp_nxt   = amp_val;
        wave_nxt  = wave_val;
        dirty_set = 3'b000;
        unique case (1'b1)
            (field_sel == 2'd0): begin
                if (step_up && freq_val < 8'(FREQ_MAX)) begin
                    freq_nxt     = freq_val + 8'd1;
                    dirty_set[0] = 1'b1;
                end else if (step_dn && freq_val != 8'd0) begin
                    freq_nxt     = freq_val - 8'd1;
                    dirty_set[0] = 1'b1;
                end
            end
            (field_sel == 2'd1): begin
                if (step_up && amp_val < 8'(AMP_MAX)) begin
                    amp_nxt      = amp_val + 8'd1;
                    dirty_set[1] = 1'b1;
                end else if (step_dn && amp_val != 8'd0) begin
                    amp_nxt      = amp_val - 8'd1;
                    dirty_set[1] = 1'b1;
                end
            end
            (field_sel == 2'd2): begin
                if (step_up) begin
                    wave_nxt = (wave_val == 2'(WAVE_COUNT - 1)) ?
                               2'd0 : wave_val + 2'd1;
                    dirty_set[2] = 1'b1;
                end else if (step_dn) begin
                    wave_nxt = (wave_val == 2'd0) ?
                               2'(WAVE_COUNT - 1) : wave_val - 2'd1;
                    dirty_set[2] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pick_idx  = 2'd2;
        pick_data = {6'd0, wave_val};
        if (dirty[0]) begin
            pick_idx  = 2'd0;
            pick_data = freq_val;
        end else if (dirty[1]) begin
            pick_idx  = 2'd1;
            pick_data = amp_val;
        end
        dirty_clr = 3'b000;
        if (state == S_IDLE && dirty != 3'b000) begin
            dirty_clr[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync     <= 2'b00;
            b_sync     <= 2'b00;
            btn_sync   <= 2'b00;
            enc_prev   <= 2'b00;
            enc_err    <= 1'b0;
            db_cnt     <= '0;
            btn_stable <= 1'b0;
            field_sel  <= 2'd0;
            freq_val   <= 8'd0;
            amp_val    <= 8'd0;
            wave_val   <= 2'd0;
            dirty      <= 3'b000;
            state      <= S_IDLE;
            cfg_valid  <= 1'b0;
            cfg_addr   <= 2'd0;
            cfg_data   <= 8'd0;
        end else begin
            a_sync   <= {a_sync[0], enc_a};
            b_sync   <= {b_sync[0], enc_b};
            btn_sync <= {btn_sync[0], btn};
            enc_prev <= enc_cur;
            enc_err  <= illegal;

            if (btn_sync[1] == btn_stable || db_done) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
            if (db_done) begin
                btn_stable <= btn_sync[1];
            end

            freq_val <= freq_nxt;
            amp_val  <= amp_nxt;
            wave_val <= wave_nxt;
            if (press) begin
                field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
            end

            // A new change wins over the launch clearing the same bit.
            dirty <= (dirty & ~dirty_clr) | dirty_set;

            case (state)
                S_IDLE: begin
                    if (dirty != 3'b000) begin
                        cfg_addr  <= pick_idx;
                        cfg_data  <= pick_data;
                        cfg_valid <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                default: begin
                    if (cfg_ready) begin
                        cfg_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Scoreboard bench for encoder_param_ctrl: detent-level reference model
// feeds an expected-transfer queue drained by an independent monitor.
module tb_encoder_param_ctrl;

    localparam int DEB   = 16;
    localparam int FMAX  = 255;
    localparam int AMAX  = 100;
    localparam int WCNT  = 4;
    localparam int HOLD  = 6;

    logic       clk;
    logic       rst;
    logic       enc_a;
    logic       enc_b;
    logic       btn;
    logic       cfg_ready;
    logic [1:0] field_sel;
    logic [7:0] freq_val;
    logic [7:0] amp_val;
    logic [1:0] wave_val;
    logic       cfg_valid;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       enc_err;

    encoder_param_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .FREQ_MAX(FMAX),
        .AMP_MAX(AMAX),
        .WAVE_COUNT(WCNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .btn(btn),
        .cfg_ready(cfg_ready),
        .field_sel(field_sel),
        .freq_val(freq_val),
        .amp_val(amp_val),
        .wave_val(wave_val),
        .cfg_valid(cfg_valid),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .enc_err(enc_err)
    );

    int checks;
    int errors;
    int err_cnt;
    int hs_cnt;
    int last_data;
    int zero_run;
    bit rdy_rand;
    bit auto_push;

    logic [9:0] exp_q[$];

    int m_sel;
    int m_freq;
    int m_amp;
    int m_wave;

    logic [1:0] cw_pat[4];
    logic [1:0] ccw_pat[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit         stalled;
        logic [9:0] held;
        logic [9:0] e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (enc_err) err_cnt++;
            if (!rst && cfg_valid) begin
                if (stalled) begin
                    checks++;
                    if ({cfg_addr, cfg_data} != held) begin
                        errors++;
                        $display("FAIL hold actual=%h required=%h",
                                 {cfg_addr, cfg_data}, held);
                    end
                end
                if (cfg_ready) begin
                    hs_cnt++;
                    last_data = int'(cfg_data);
                    stalled   = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL xfer actual=%h required=none",
                                 {cfg_addr, cfg_data});
                    end else begin
                        e = exp_q.pop_front();
                        if ({cfg_addr, cfg_data} != e) begin
                            errors++;
                            $display("FAIL xfer actual=%h required=%h",
                                     {cfg_addr, cfg_data}, e);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held    = {cfg_addr, cfg_data};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) begin
            if (zero_run >= 3 || $urandom_range(0, 1) == 1) begin
                cfg_ready = 1'b1;
                zero_run  = 0;
            end else begin
                cfg_ready = 1'b0;
                zero_run++;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        btn   = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        m_sel  = 0;
        m_freq = 0;
        m_amp  = 0;
        m_wave = 0;
    endtask

    task automatic m_step(input int dir);
        int v;
        int nv;
        if (m_sel == 0) begin
            v  = m_freq;
            nv = (v + dir > FMAX) ? FMAX : (v + dir < 0) ? 0 : v + dir;
            m_freq = nv;
        end else if (m_sel == 1) begin
            v  = m_amp;
            nv = (v + dir > AMAX) ? AMAX : (v + dir < 0) ? 0 : v + dir;
            m_amp = nv;
        end else begin
            v  = m_wave;
            nv = (v + dir + WCNT) % WCNT;
            m_wave = nv;
        end
        if (nv != v && auto_push) exp_q.push_back({2'(m_sel), 8'(nv)});
    endtask

    task automatic detent(input bit cw);
        m_step(cw ? 1 : -1);
        for (int i = 0; i < 4; i++) begin
            {enc_a, enc_b} = cw ? cw_pat[i] : ccw_pat[i];
            ticks(HOLD);
        end
    endtask

    task automatic press();
        btn = 1'b1;
        ticks(2 * DEB);
        btn = 1'b0;
        ticks(2 * DEB);
        m_sel = (m_sel + 1) % 3;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!cfg_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, int'(cfg_valid), 1);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_sel"}, int'(field_sel), m_sel);
        chk({tag, "_freq"}, int'(freq_val), m_freq);
        chk({tag, "_amp"}, int'(amp_val), m_amp);
        chk({tag, "_wave"}, int'(wave_val), m_wave);
    endtask

    initial begin
        int hs0;
        int e0;
        int r;
        cw_pat  = '{2'b01, 2'b11, 2'b10, 2'b00};
        ccw_pat = '{2'b10, 2'b11, 2'b01, 2'b00};
        checks    = 0;
        errors    = 0;
        err_cnt   = 0;
        hs_cnt    = 0;
        last_data = -1;
        zero_run  = 0;
        rdy_rand  = 1'b0;
        auto_push = 1'b1;
        cfg_ready = 1'b1;
        rst       = 1'b0;
        enc_a     = 1'b0;
        enc_b     = 1'b0;
        btn       = 1'b0;

        do_reset();
        chk("rst_valid", int'(cfg_valid), 0);
        chk("rst_addr", int'(cfg_addr), 0);
        chk("rst_data", int'(cfg_data), 0);
        chk("rst_err", int'(enc_err), 0);
        chk_model("rst");

        // Three clean CW detents on freq.
        for (int i = 0; i < 3; i++) detent(1'b1);
        ticks(10);
        chk("t1_freq", int'(freq_val), 3);
        chk("t1_xfers", hs_cnt, 3);
        chk("t1_err", err_cnt, 0);
        chk("t1_q", exp_q.size(), 0);

        // CCW at zero is blocked; amp saturates at its limit.
        do_reset();
        hs0 = hs_cnt;
        detent(1'b0);
        ticks(10);
        chk("t2_freq", int'(freq_val), 0);
        chk("t2_noxfer", hs_cnt, hs0);
        press();
        chk("t2_sel", int'(field_sel), 1);
        for (int i = 0; i < 102; i++) detent(1'b1);
        ticks(10);
        chk("t2_amp", int'(amp_val), AMAX);
        chk("t2_last", last_data, AMAX);
        chk("t2_q", exp_q.size(), 0);

        // Bouncy button gives exactly one advance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            tick();
            btn = 1'b0;
            tick();
        end
        btn = 1'b1;
        ticks(2 * DEB);
        btn = 1'b0;
        ticks(2 * DEB);
        m_sel = 1;
        chk("t3_bounce", int'(field_sel), 1);
        for (int i = 0; i < 3; i++) press();
        chk("t3_wrap", int'(field_sel), 1);

        // Waveform wraps both ways.
        press();
        for (int i = 0; i < 3; i++) detent(1'b1);
        chk("t4_wave3", int'(wave_val), 3);
        detent(1'b1);
        ticks(10);
        chk("t4_wave0", int'(wave_val), 0);
        chk("t4_last", last_data, 0);
        detent(1'b0);
        ticks(10);
        chk("t4_wave_back", int'(wave_val), 3);
        chk("t4_q", exp_q.size(), 0);

        // Stalled sink: first value held, changes coalesce into one more.
        do_reset();
        auto_push = 1'b0;
        cfg_ready = 1'b0;
        hs0 = hs_cnt;
        exp_q.push_back({2'd0, 8'd1});
        exp_q.push_back({2'd0, 8'd5});
        detent(1'b1);
        wait_valid("t5_launch");
        chk("t5_data1", int'(cfg_data), 1);
        for (int i = 0; i < 4; i++) detent(1'b1);
        chk("t5_held", int'(cfg_data), 1);
        cfg_ready = 1'b1;
        ticks(20);
        chk("t5_xfers", hs_cnt - hs0, 2);
        chk("t5_freq", int'(freq_val), 5);
        chk("t5_q", exp_q.size(), 0);
        auto_push = 1'b1;

        // Illegal jump, then reset in the middle of a transfer.
        e0 = err_cnt;
        {enc_a, enc_b} = 2'b11;
        ticks(HOLD);
        {enc_a, enc_b} = 2'b01;
        ticks(HOLD);
        {enc_a, enc_b} = 2'b00;
        ticks(HOLD);
        chk("t6_err", err_cnt - e0, 1);
        chk("t6_freq", int'(freq_val), 5);
        cfg_ready = 1'b0;
        m_step(1);
        {enc_a, enc_b} = 2'b01;
        wait_valid("t6_launch");
        {enc_a, enc_b} = 2'b00;
        ticks(HOLD);
        do_reset();
        chk("t6_rst_valid", int'(cfg_valid), 0);
        chk_model("t6_rst");
        cfg_ready = 1'b1;
        hs0 = hs_cnt;
        ticks(10);
        chk("t6_noreplay", hs_cnt, hs0);

        // Random detents and presses with a randomly stalling sink.
        rdy_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) detent(1'b1);
            else if (r < 8) detent(1'b0);
            else press();
        end
        rdy_rand  = 1'b0;
        cfg_ready = 1'b1;
        ticks(20);
        chk_model("rnd");
        chk("rnd_q", exp_q.size(), 0);
        chk("rnd_err", err_cnt - e0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
